storage_controller: RTL and testbench
=====================================

STORAGE_CONTROLLER -- requirements
Module: storage_controller

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports listed clock and reset first:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- memory_access  in  1  request valid; held high until out_valid seen
- memory_is_writing  in  1  1=write, 0=read; sampled with request
- addr  in  32  byte/word address of request
- d_in  in  32  write data
- mem_be  in  4  write byte enables; mem_be[n] enables d_in[8n+7:8n]
- set_programming_mode  in  1  1=SPI passthrough mode
- external_storage_spi_miso  in  1  flash data in
- programming_spi_cs_n / programming_spi_sck / programming_spi_mosi  in  1 each  external programmer SPI
- d_out  out  32  read data
- out_valid  out  1  request complete
- external_storage_spi_cs_n / external_storage_spi_sck / external_storage_spi_mosi  out  1 each  flash SPI
- programming_spi_miso  out  1  data back to programmer

Function
REQ-002 SHALL contain an internal SRAM of 2048 x 32-bit words, indexed by addr[10:0]; region selected when addr[31:11]==0.
REQ-003 Addresses with addr[31:11]!=0 SHALL map to external SPI flash.
REQ-004 Request accepted on rising edge in IDLE with memory_access=1 and set_programming_mode=0.
REQ-005 SRAM write: word addr[10:0] updated on the accept edge, only enabled bytes; next cycle out_valid=1.
REQ-006 SRAM read: d_out = word addr[10:0] and out_valid=1 from the cycle after accept (1-cycle latency).
REQ-007 External write: no SPI activity, data discarded, out_valid=1 next cycle (acknowledge only).
REQ-008 External read: cs_n low, shift out MSB-first 8'h03 opcode then addr[23:0] (32 bits), then shift in 32 data bits; cs_n high; out_valid=1.
REQ-009 Data byte order: first received byte -> d_out[7:0], second -> [15:8], third -> [23:16], fourth -> [31:24]; each byte MSB-first.
REQ-010 SPI mode 0: sck idles low, sck toggles every clk cycle during transfer (f_sck = f_clk/2); mosi changes while sck low and is stable at each sck rising edge; miso sampled on the clk edge that drives sck high.
REQ-011 States: IDLE, SRAM_ACC, SPI_CMD (32 sck pulses), SPI_DATA (32 sck pulses), DONE.
REQ-012 DONE holds out_valid=1 and d_out stable while memory_access=1; memory_access=0 -> IDLE, out_valid=0 next cycle; no new request accepted until back in IDLE.
REQ-013 d_out SHALL keep the last read value until the next read completes; writes do not change d_out.
REQ-014 Changes to addr/d_in/memory_is_writing after acceptance SHALL be ignored (captured at accept).
REQ-015 set_programming_mode=1: external_storage_spi_cs_n/sck/mosi = programming_spi_cs_n/sck/mosi and programming_spi_miso = external_storage_spi_miso, purely combinational (same cycle), independent of reset and FSM state.
REQ-016 set_programming_mode=0: programming_spi_miso=0; flash SPI driven by controller.
REQ-017 set_programming_mode rising mid-transaction: FSM aborts to IDLE next edge, out_valid=0, no data written/returned.
REQ-018 memory_access dropped mid-SPI transfer: transfer still completes, then DONE immediately exits to IDLE.

Reset
REQ-019 rst=0 SHALL asynchronously force: FSM IDLE, out_valid=0, d_out=0, internal cs_n=1, sck=0, mosi=0, shift counters 0.
REQ-020 SRAM contents SHALL NOT be reset.
REQ-021 Reset during SPI transfer SHALL immediately raise cs_n and lower sck (when not in programming mode).

Verification
REQ-022 Passthrough: mode=1, drive all 8 combos of programming cs_n/sck/mosi -> flash outputs equal inputs each cycle; flash miso 0/1 -> programming_spi_miso 0/1.
REQ-023 SRAM sweep: for i=0..0x7FF write addr=i, d_in=i, be=4'hF; then read addr=i -> out_valid=1 one cycle after accept, d_out==i.
REQ-024 Byte enables: write 0xFFFFFFFF to addr 5, then 0x12345678 with be=4'b0101 -> read returns 0xFF34FF78.
REQ-025 External read addr=0x0000_1001: at successive sck rising edges mosi = bits of 0x03 then 0x001001 MSB-first (32 bits); miso stream 0xAA,0xBB,0xCC,0xDD -> d_out=0xDDCCBBAA, out_valid=1, cs_n=1.
REQ-026 Handshake: hold memory_access in DONE -> out_valid stays 1, no second transaction; drop -> out_valid=0 next cycle.
REQ-027 Reset mid external read -> cs_n=1, sck=0, out_valid=0 immediately; subsequent SRAM read works.

Source files
------------

// File: rtl/storage_controller.sv
// Memory request controller: 2048x32 internal SRAM for the low 8 KiB window and a mode-0 SPI
// flash reader for the rest, plus a combinational SPI passthrough for an external programmer.
module storage_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        memory_access,
  input  logic        memory_is_writing,
  input  logic [31:0] addr,
  input  logic [31:0] d_in,
  input  logic [3:0]  mem_be,
  input  logic        set_programming_mode,
  input  logic        external_storage_spi_miso,
  input  logic        programming_spi_cs_n,
  input  logic        programming_spi_sck,
  input  logic        programming_spi_mosi,
  output logic [31:0] d_out,
  output logic        out_valid,
  output logic        external_storage_spi_cs_n,
  output logic        external_storage_spi_sck,
  output logic        external_storage_spi_mosi,
  output logic        programming_spi_miso
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StSramAcc = 3'd1;
  localparam logic [2:0] StSpiCmd  = 3'd2;
  localparam logic [2:0] StSpiData = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;

  logic [31:0] mem [2048];

  logic [2:0]  state_q, state_d;
  logic [31:0] d_out_q, d_out_d;
  logic        cs_n_q, cs_n_d;
  logic        sck_q, sck_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] rx_q, rx_d;
  logic [4:0]  cnt_q, cnt_d;

  logic accept;
  logic is_sram;
  logic int_mosi;

  assign accept  = (state_q == StIdle) && memory_access && !set_programming_mode;
  assign is_sram = (addr[31:11] == 21'd0);

  always_comb begin
    state_d = state_q;
    d_out_d = d_out_q;
    cs_n_d  = cs_n_q;
    sck_d   = sck_q;
    shift_d = shift_q;
    rx_d    = rx_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_sram) begin
            state_d = StSramAcc;
            if (!memory_is_writing) d_out_d = mem[addr[10:0]];
          end else if (memory_is_writing) begin
            state_d = StDone;
          end else begin
            state_d = StSpiCmd;
            cs_n_d  = 1'b0;
            sck_d   = 1'b0;
            cnt_d   = 5'd0;
            shift_d = {8'h03, addr[23:0]};
          end
        end
      end
      StSramAcc: state_d = memory_access ? StDone : StIdle;
      StSpiCmd: begin
        // mosi advances only on the edge that takes sck low
        if (!sck_q) begin
          sck_d = 1'b1;
        end else begin
          sck_d   = 1'b0;
          shift_d = {shift_q[30:0], 1'b0};
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = StSpiData;
        end
      end
      StSpiData: begin
        if (!sck_q) begin
          sck_d = 1'b1;
          rx_d  = {rx_q[30:0], external_storage_spi_miso};
        end else begin
          sck_d = 1'b0;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = StDone;
            cs_n_d  = 1'b1;
            // first byte received lands in the least significant lane
            d_out_d = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
          end
        end
      end
      StDone:  if (!memory_access) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (set_programming_mode && (state_q != StIdle)) begin
      state_d = StIdle;
      cs_n_d  = 1'b1;
      sck_d   = 1'b0;
      cnt_d   = 5'd0;
      shift_d = 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      d_out_q <= 32'd0;
      cs_n_q  <= 1'b1;
      sck_q   <= 1'b0;
      shift_q <= 32'd0;
      rx_q    <= 32'd0;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      d_out_q <= d_out_d;
      cs_n_q  <= cs_n_d;
      sck_q   <= sck_d;
      shift_q <= shift_d;
      rx_q    <= rx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && is_sram && memory_is_writing) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[addr[10:0]][8*b +: 8] <= d_in[8*b +: 8];
      end
    end
  end

  assign int_mosi  = (state_q == StSpiCmd) && shift_q[31];
  assign d_out     = d_out_q;
  assign out_valid = (state_q == StSramAcc) || (state_q == StDone);

  assign external_storage_spi_cs_n = set_programming_mode ? programming_spi_cs_n : cs_n_q;
  assign external_storage_spi_sck  = set_programming_mode ? programming_spi_sck  : sck_q;
  assign external_storage_spi_mosi = set_programming_mode ? programming_spi_mosi : int_mosi;
  assign programming_spi_miso      = set_programming_mode & external_storage_spi_miso;

endmodule

// File: tb/tb_storage_controller.sv
// Directed bench for storage_controller: SRAM vector table and sweep, passthrough, SPI flash read
// against a bit-level flash model, handshake, abort and reset corner cases.
module tb_storage_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        memory_access, memory_is_writing;
  logic [31:0] addr, d_in;
  logic [3:0]  mem_be;
  logic        set_programming_mode;
  logic        external_storage_spi_miso;
  logic        programming_spi_cs_n, programming_spi_sck, programming_spi_mosi;
  logic [31:0] d_out;
  logic        out_valid;
  logic        external_storage_spi_cs_n, external_storage_spi_sck, external_storage_spi_mosi;
  logic        programming_spi_miso;

  storage_controller dut (
    .clk                       (clk),
    .rst                       (rst),
    .memory_access             (memory_access),
    .memory_is_writing         (memory_is_writing),
    .addr                      (addr),
    .d_in                      (d_in),
    .mem_be                    (mem_be),
    .set_programming_mode      (set_programming_mode),
    .external_storage_spi_miso (external_storage_spi_miso),
    .programming_spi_cs_n      (programming_spi_cs_n),
    .programming_spi_sck       (programming_spi_sck),
    .programming_spi_mosi      (programming_spi_mosi),
    .d_out                     (d_out),
    .out_valid                 (out_valid),
    .external_storage_spi_cs_n (external_storage_spi_cs_n),
    .external_storage_spi_sck  (external_storage_spi_sck),
    .external_storage_spi_mosi (external_storage_spi_mosi),
    .programming_spi_miso      (programming_spi_miso)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Flash model: records mosi at sck rise, serves 0xAA,0xBB,0xCC,0xDD after the 32 command bits
  logic [31:0] flash_data = 32'hAABBCCDD;
  logic [31:0] cmd_cap;
  int rise_cnt, fall_cnt;

  always @(posedge external_storage_spi_sck) begin
    if (!set_programming_mode && !external_storage_spi_cs_n) begin
      if (rise_cnt < 32) cmd_cap = {cmd_cap[30:0], external_storage_spi_mosi};
      rise_cnt = rise_cnt + 1;
    end
  end

  always @(negedge external_storage_spi_sck) begin
    if (!set_programming_mode && !external_storage_spi_cs_n) begin
      fall_cnt = fall_cnt + 1;
      if (fall_cnt >= 32 && fall_cnt < 64) external_storage_spi_miso = flash_data[63-fall_cnt];
    end
  end

  task automatic flash_clear();
    rise_cnt = 0;
    fall_cnt = 0;
    cmd_cap  = 32'd0;
    external_storage_spi_miso = 1'b0;
  endtask

  // One full request/handshake; request inputs are scrambled right after acceptance
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, output logic [31:0] rd, output int lat,
                        output logic cs_v);
    @(negedge clk);
    memory_access = 1'b1; memory_is_writing = w; addr = a; d_in = d; mem_be = be;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        memory_is_writing = ~w; addr = ~a; d_in = ~d; mem_be = ~be;
      end
    end while (!out_valid && lat < 400);
    rd   = d_out;
    cs_v = external_storage_spi_cs_n;
    @(negedge clk);
    memory_access = 1'b0;
    @(posedge clk); #1;
    check("ov_drop", {31'd0, out_valid}, 32'd0);
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] rd;
    logic [31:0] held;
    logic        cs_v;
    int          lat;
    int          n;

    vecs[0]  = '{1'b1, 32'h0000_0005, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000};
    vecs[1]  = '{1'b1, 32'h0000_0005, 32'h1234_5678, 4'h5, 32'h0000_0000};
    vecs[2]  = '{1'b0, 32'h0000_0005, 32'h0,         4'hF, 32'hFF34_FF78};
    vecs[3]  = '{1'b1, 32'h0000_07FF, 32'hA5A5_A5A5, 4'hF, 32'hFF34_FF78};
    vecs[4]  = '{1'b0, 32'h0000_07FF, 32'h0,         4'hF, 32'hA5A5_A5A5};
    vecs[5]  = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'hF, 32'hA5A5_A5A5};
    vecs[6]  = '{1'b1, 32'h0000_0010, 32'hAABB_CCDD, 4'hA, 32'hA5A5_A5A5};
    vecs[7]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'hAA22_CC44};
    vecs[8]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 32'hAA22_CC44};
    vecs[9]  = '{1'b1, 32'h0000_0800, 32'hDEAD_BEEF, 4'hF, 32'hAA22_CC44};
    vecs[10] = '{1'b0, 32'h0000_0000, 32'h0,         4'hF, 32'hCAFE_F00D};
    vecs[11] = '{1'b1, 32'h0003_0000, 32'h5555_5555, 4'hF, 32'hCAFE_F00D};

    rst = 1'b0;
    memory_access = 1'b0; memory_is_writing = 1'b0; addr = 32'd0; d_in = 32'd0; mem_be = 4'h0;
    set_programming_mode = 1'b0;
    programming_spi_cs_n = 1'b1; programming_spi_sck = 1'b0; programming_spi_mosi = 1'b0;
    flash_clear();
    external_storage_spi_miso = 1'b1;
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_d_out", d_out, 32'd0);
    check("rst_cs_n", {31'd0, external_storage_spi_cs_n}, 32'd1);
    check("rst_sck", {31'd0, external_storage_spi_sck}, 32'd0);
    check("rst_mosi", {31'd0, external_storage_spi_mosi}, 32'd0);
    check("rst_prog_miso", {31'd0, programming_spi_miso}, 32'd0);
    // passthrough must work even while held in reset
    set_programming_mode = 1'b1;
    programming_spi_cs_n = 1'b0; programming_spi_sck = 1'b1; programming_spi_mosi = 1'b1;
    #1;
    check("rst_pass", {29'd0, external_storage_spi_cs_n, external_storage_spi_sck,
                       external_storage_spi_mosi, programming_spi_miso}, 32'b0111);
    set_programming_mode = 1'b0;
    programming_spi_cs_n = 1'b1; programming_spi_sck = 1'b0; programming_spi_mosi = 1'b0;
    external_storage_spi_miso = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Passthrough, all programmer line combinations and both miso values
    @(negedge clk);
    set_programming_mode = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = i[3:0];
      programming_spi_cs_n = v[2]; programming_spi_sck = v[1]; programming_spi_mosi = v[0];
      external_storage_spi_miso = v[3];
      @(posedge clk); #1;
      check("pass", {28'd0, programming_spi_miso, external_storage_spi_cs_n,
                     external_storage_spi_sck, external_storage_spi_mosi}, {28'd0, v});
    end
    @(negedge clk);
    set_programming_mode = 1'b0;
    programming_spi_cs_n = 1'b0; programming_spi_sck = 1'b1; programming_spi_mosi = 1'b1;
    external_storage_spi_miso = 1'b1;
    #1;
    check("mode0_lines", {28'd0, programming_spi_miso, external_storage_spi_cs_n,
                          external_storage_spi_sck, external_storage_spi_mosi}, 32'b0100);
    programming_spi_cs_n = 1'b1; programming_spi_sck = 1'b0; programming_spi_mosi = 1'b0;
    external_storage_spi_miso = 1'b0;

    for (int i = 0; i < 12; i++) begin
      access(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].be, rd, lat, cs_v);
      check($sformatf("vec%0d_lat", i), lat, 32'd1);
      check($sformatf("vec%0d_dout", i), rd, vecs[i].exp);
    end

    // External read
    flash_clear();
    access(1'b0, 32'h0000_1001, 32'h0, 4'hF, rd, lat, cs_v);
    check("ext_lat", lat, 32'd129);
    check("ext_cmd", cmd_cap, 32'h0300_1001);
    check("ext_rises", rise_cnt, 32'd64);
    check("ext_dout", rd, 32'hDDCC_BBAA);
    check("ext_cs_n", {31'd0, cs_v}, 32'd1);

    // Held handshake in DONE, then release
    @(negedge clk);
    memory_access = 1'b1; memory_is_writing = 1'b0; addr = 32'h5; mem_be = 4'hF;
    @(posedge clk); #1;
    check("hold_first", {31'd0, out_valid}, 32'd1);
    held = d_out;
    check("hold_data", held, 32'hFF34_FF78);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_dout", d_out, held);
    end
    @(negedge clk);
    memory_access = 1'b0;
    @(posedge clk); #1;
    check("hold_drop", {31'd0, out_valid}, 32'd0);

    // memory_access dropped mid transfer: completes, one cycle of out_valid
    flash_clear();
    @(negedge clk);
    memory_access = 1'b1; memory_is_writing = 1'b0; addr = 32'h0000_1001;
    repeat (20) @(posedge clk);
    @(negedge clk);
    memory_access = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid && n < 300);
    check("drop_valid", {31'd0, out_valid}, 32'd1);
    check("drop_dout", d_out, 32'hDDCC_BBAA);
    @(posedge clk); #1;
    check("drop_one_cycle", {31'd0, out_valid}, 32'd0);

    // Programming mode raised mid transfer aborts
    flash_clear();
    @(negedge clk);
    memory_access = 1'b1; addr = 32'h0000_2000;
    repeat (10) @(posedge clk);
    @(negedge clk);
    set_programming_mode = 1'b1; memory_access = 1'b0;
    @(negedge clk);
    set_programming_mode = 1'b0;
    #1;
    check("abort_cs_n", {31'd0, external_storage_spi_cs_n}, 32'd1);
    check("abort_sck", {31'd0, external_storage_spi_sck}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_dout", d_out, 32'hDDCC_BBAA);

    // SRAM sweep
    for (int i = 0; i < 2048; i++) access(1'b1, i, i, 4'hF, rd, lat, cs_v);
    for (int i = 0; i < 2048; i++) begin
      access(1'b0, i, 32'h0, 4'hF, rd, lat, cs_v);
      check("sweep_lat", lat, 32'd1);
      check("sweep_dout", rd, i);
    end

    // Reset mid external read
    flash_clear();
    @(negedge clk);
    memory_access = 1'b1; memory_is_writing = 1'b0; addr = 32'h0000_1001;
    repeat (30) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("mid_rst_cs_n", {31'd0, external_storage_spi_cs_n}, 32'd1);
    check("mid_rst_sck", {31'd0, external_storage_spi_sck}, 32'd0);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_dout", d_out, 32'd0);
    memory_access = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    access(1'b0, 32'h0000_0005, 32'h0, 4'hF, rd, lat, cs_v);
    check("post_rst_lat", lat, 32'd1);
    check("post_rst_dout", rd, 32'h0000_0005);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
